popcount19_ternary_acc: RTL and testbench

Sequential accumulation and activation stage placed directly downstream of a pair of 19-input popcount units in a ternary neuron. Each beat, it takes the positive-weight popcount and the negative-weight popcount of one 19-input chunk and adds their difference to a signed running sum. On the last chunk of a neuron it compares the sum against two thresholds and emits a ternary activation (+1/0/−1) through a valid/ready handshake. The block can time-multiplex one popcount pair across neurons wider than 19 inputs.

---
 rtl/popcount19_ternary_acc.sv | 100 ++++++++++
 tb/tb_popcount19_ternary_acc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/popcount19_ternary_acc.sv
// popcount19_ternary_acc: signed accumulation of popcount differences with ternary threshold activation.
// Optional saturation of every sum update when POPCNT_ACC_SAT_EN is defined (wraps otherwise).
`default_nettype none

module popcount19_ternary_acc #(
    parameter int ACC_W = 10,
    parameter int TH_HI = 4,
    parameter int TH_LO = -4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_pos,
    input  logic [4:0]       in_neg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_sum
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic signed [ACC_W-1:0] TH_HI_V = ACC_W'(TH_HI);
    localparam logic signed [ACC_W-1:0] TH_LO_V = ACC_W'(TH_LO);
`ifdef POPCNT_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [0:0]       state;
    logic [ACC_W-1:0] sum;
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] next_sum;
    logic [1:0]       act_next;
    logic             accept;

    // in_ready depends on state alone, so no combinational path from out_ready.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid & in_ready;

    assign wide = {sum[ACC_W-1], sum}
                + {{(ACC_W-4){1'b0}}, in_pos}
                - {{(ACC_W-4){1'b0}}, in_neg};

    always_comb begin
        next_sum = wide[ACC_W-1:0];
`ifdef POPCNT_ACC_SAT_EN
        // Top two bits disagree only when the ACC_W+1-bit result is out of range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            next_sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_comb begin
        act_next = 2'b00;
        if ($signed(next_sum) >= TH_HI_V) begin
            act_next = 2'b01;
        end else if ($signed(next_sum) <= TH_LO_V) begin
            act_next = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_ACC;
            sum     <= '0;
            out_act <= 2'b00;
            out_sum <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_sum <= next_sum;
                            out_act <= act_next;
                            sum     <= '0;
                            state   <= ST_HOLD;
                        end else begin
                            sum <= next_sum;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_popcount19_ternary_acc.sv
// Directed, table-driven bench for popcount19_ternary_acc (ACC_W=10 and ACC_W=7 instances).
`default_nettype none

module tb_popcount19_ternary_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_pos;
    logic [4:0] in_neg;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [1:0] out_act;
    logic [9:0] out_sum;
    logic       in_ready7, out_valid7;
    logic [1:0] out_act7;
    logic [6:0] out_sum7;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    popcount19_ternary_acc #(.ACC_W(10), .TH_HI(4), .TH_LO(-4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_act(out_act), .out_sum(out_sum)
    );

    popcount19_ternary_acc #(.ACC_W(7), .TH_HI(4), .TH_LO(-4)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready7),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid7), .out_ready(out_ready),
        .out_act(out_act7), .out_sum(out_sum7)
    );

    typedef struct {
        int       pos;
        int       neg;
        bit       last;
        int       exp_sum;
        int       exp_sum7;
        bit [1:0] exp_act;
        bit [1:0] exp_act7;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int p, input int n, input bit last);
        in_valid = 1'b1;
        in_pos   = 5'(p);
        in_neg   = 5'(n);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready_after_hs", int'(in_ready), 1);
        check("out_valid_after_hs", int'(out_valid), 0);
    endtask

    task automatic expect_out(input string name, input int s, input bit [1:0] a);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_in_ready"}, int'(in_ready), 0);
        check({name, "_sum"}, int'($signed(out_sum)), s);
        check({name, "_act"}, int'(out_act), int'(a));
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{10, 3, 1'b1,   7,   7, 2'b01, 2'b01};
        vecs[1]  = '{ 5, 5, 1'b0,   0,   0, 2'b00, 2'b00};
        vecs[2]  = '{ 2, 4, 1'b0,   0,   0, 2'b00, 2'b00};
        vecs[3]  = '{ 1, 0, 1'b1,  -1,  -1, 2'b00, 2'b00};
        vecs[4]  = '{ 0, 9, 1'b1,  -9,  -9, 2'b11, 2'b11};
        vecs[5]  = '{ 4, 0, 1'b1,   4,   4, 2'b01, 2'b01};
        vecs[6]  = '{ 0, 4, 1'b1,  -4,  -4, 2'b11, 2'b11};
        vecs[7]  = '{ 3, 0, 1'b1,   3,   3, 2'b00, 2'b00};
        vecs[8]  = '{ 0, 3, 1'b1,  -3,  -3, 2'b00, 2'b00};
        vecs[9]  = '{ 0,31, 1'b1, -31, -31, 2'b11, 2'b11};
        vecs[10] = '{20,19, 1'b0,   0,   0, 2'b00, 2'b00};
        vecs[11] = '{19,20, 1'b0,   0,   0, 2'b00, 2'b00};
        vecs[12] = '{ 9, 4, 1'b1,   5,   5, 2'b01, 2'b01};

        rst_n = 1'b0; in_valid = 1'b0; in_pos = '0; in_neg = '0;
        in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_act", int'(out_act), 0);
        check("rst_out_sum", int'(out_sum), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            beat(vecs[i].pos, vecs[i].neg, vecs[i].last);
            if (vecs[i].last) begin
                expect_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_act);
                check($sformatf("vec%0d_sum7", i), int'($signed(out_sum7)), vecs[i].exp_sum7);
                check($sformatf("vec%0d_act7", i), int'(out_act7), int'(vecs[i].exp_act7));
                handshake();
            end else begin
                check($sformatf("vec%0d_no_valid", i), int'(out_valid), 0);
                check($sformatf("vec%0d_ready", i), int'(in_ready), 1);
            end
        end

        // HOLD stall with a beat offered that must be ignored
        beat(6, 0, 1'b1);
        in_valid = 1'b1; in_pos = 5'd20; in_neg = 5'd0; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            expect_out($sformatf("stall%0d", c), 6, 2'b01);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake();
        beat(0, 1, 1'b1);
        expect_out("after_stall", -1, 2'b00);
        handshake();

        // in_valid gap inside a neuron holds the partial sum
        beat(5, 2, 1'b0);
        step(); step(); step();
        check("gap_no_valid", int'(out_valid), 0);
        beat(0, 0, 1'b1);
        expect_out("gap", 3, 2'b00);
        handshake();

        // Overflow: 124 fits 10 bits; 7-bit instance saturates or wraps
        beat(31, 0, 1'b0);
        beat(31, 0, 1'b0);
        beat(31, 0, 1'b0);
        beat(31, 0, 1'b1);
        expect_out("ovf10", 124, 2'b01);
`ifdef POPCNT_ACC_SAT_EN
        check("ovf7_sum", int'($signed(out_sum7)), 63);
        check("ovf7_act", int'(out_act7), 1);
`else
        check("ovf7_sum", int'($signed(out_sum7)), -4);
        check("ovf7_act", int'(out_act7), 3);
`endif
        handshake();

        // Reset mid-neuron discards the partial sum
        beat(10, 0, 1'b0);
        beat(10, 0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_ready", int'(in_ready), 1);
        beat(1, 0, 1'b1);
        expect_out("midrst", 1, 2'b00);

        // Reset during HOLD drops the pending activation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("holdrst_valid", int'(out_valid), 0);
        check("holdrst_ready", int'(in_ready), 1);
        check("holdrst_sum", int'(out_sum), 0);
        check("holdrst_act", int'(out_act), 0);

        // Back-to-back neurons with out_ready held high
        out_ready = 1'b1;
        beat(8, 0, 1'b1);
        check("bb_valid", int'(out_valid), 1);
        check("bb_sum", int'($signed(out_sum)), 8);
        step();
        check("bb_ready", int'(in_ready), 1);
        beat(0, 8, 1'b1);
        check("bb2_sum", int'($signed(out_sum)), -8);
        check("bb2_act", int'(out_act), 3);
        out_ready = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
